// File: rtl/fifo_level.sv
// Occupancy-tracked FIFO with almost-full/empty thresholds, sticky error flags
// and a choice of first-word fall-through or registered read data.
module fifo_level #(
  parameter int SIZE               = 16,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOST_FULL_LEVEL  = SIZE - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int FWFT               = 1,
  localparam int CW = $clog2(SIZE + 1),
  localparam int PW = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  enqueue,
  input  logic                  dequeue,
  input  logic [DATA_WIDTH-1:0] back,
  input  logic                  clearErrors,
  output logic [DATA_WIDTH-1:0] front,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  enq_ok;
  logic                  deq_ok;
  logic                  overflow_set;
  logic                  underflow_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_reg == CW'(SIZE));
  assign empty       = (count_reg == '0);
  assign almostFull  = (int'(count_reg) >= ALMOST_FULL_LEVEL);
  assign almostEmpty = (int'(count_reg) <= ALMOST_EMPTY_LEVEL);
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // A dequeue frees the slot a same-cycle enqueue into a full FIFO needs;
  // nothing commits while reset is held.
  assign enq_ok = rst_n && !flush && enqueue && (!full || dequeue);
  assign deq_ok = rst_n && !flush && dequeue && !empty;

  assign overflow_set  = enqueue && full && !dequeue && !flush;
  assign underflow_set = dequeue && empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (deq_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      unique case ({enq_ok, deq_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Setting outranks clearing so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (overflow_set)     overflow_reg <= 1'b1;
      else if (clearErrors) overflow_reg <= 1'b0;
      if (underflow_set)     underflow_reg <= 1'b1;
      else if (clearErrors)  underflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr_reg] <= back;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign front = mem[rd_ptr_reg];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] front_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      front_reg <= '0;
        else if (deq_ok) front_reg <= mem[rd_ptr_reg];
      end
      assign front = front_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// Two fifo_level instances (SIZE=5 FWFT, SIZE=16 registered read) fed the same
// stimulus and compared every cycle against queue-based reference models.
module tb_fifo_level;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enqueue = 1'b0;
  logic        dequeue = 1'b0;
  logic        clear_errors = 1'b0;
  logic [31:0] back_data = '0;

  logic [31:0] front_a, front_b;
  logic        full_a, full_b, empty_a, empty_b;
  logic        afull_a, afull_b, aempty_a, aempty_b;
  logic        ovf_a, ovf_b, unf_a, unf_b;
  logic [2:0]  count_a;
  logic [4:0]  count_b;

  int n_checks = 0;
  int n_fail = 0;
  int txn = 0;

  always #5 clk = ~clk;

  fifo_level #(.SIZE(5), .DATA_WIDTH(32), .FWFT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enqueue(enqueue), .dequeue(dequeue),
    .back(back_data), .clearErrors(clear_errors), .front(front_a), .full(full_a),
    .empty(empty_a), .almostFull(afull_a), .almostEmpty(aempty_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a));

  fifo_level #(.SIZE(16), .DATA_WIDTH(32), .FWFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .enqueue(enqueue), .dequeue(dequeue),
    .back(back_data), .clearErrors(clear_errors), .front(front_b), .full(full_b),
    .empty(empty_b), .almostFull(afull_b), .almostEmpty(aempty_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b));

  // Reference model: one queue per instance plus sticky flags and read register.
  logic [31:0] q [2][$];
  int          cap [2] = '{5, 16};
  int          fwft [2] = '{1, 0};
  logic        ovf_m [2] = '{1'b0, 1'b0};
  logic        unf_m [2] = '{1'b0, 1'b0};
  logic [31:0] fr_m [2] = '{32'h0, 32'h0};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      ovf_m[i] = 1'b0;
      unf_m[i] = 1'b0;
      fr_m[i]  = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int   n = q[i].size();
      logic set_o = enqueue && (n == cap[i]) && !dequeue && !flush;
      logic set_u = dequeue && (n == 0) && !flush;
      if (flush) q[i].delete();
      else begin
        if (dequeue && n > 0) fr_m[i] = q[i].pop_front();
        if (enqueue && (n < cap[i] || dequeue)) q[i].push_back(back_data);
      end
      ovf_m[i] = set_o ? 1'b1 : (clear_errors ? 1'b0 : ovf_m[i]);
      unf_m[i] = set_u ? 1'b1 : (clear_errors ? 1'b0 : unf_m[i]);
    end
  endtask

  task automatic check_all();
    logic [31:0] fr [2];
    logic [4:0]  cnt [2];
    logic        fl [2], em [2], af [2], ae [2], ov [2], un [2];
    fr  = '{front_a, front_b};
    cnt = '{{2'b00, count_a}, count_b};
    fl  = '{full_a, full_b};    em = '{empty_a, empty_b};
    af  = '{afull_a, afull_b};  ae = '{aempty_a, aempty_b};
    ov  = '{ovf_a, ovf_b};      un = '{unf_a, unf_b};
    for (int i = 0; i < 2; i++) begin
      int    n = q[i].size();
      string p = (i == 0) ? "a" : "b";
      check_val({p, ".count"}, 64'(cnt[i]), 64'(n));
      check_val({p, ".full"}, 64'(fl[i]), 64'(n == cap[i]));
      check_val({p, ".empty"}, 64'(em[i]), 64'(n == 0));
      check_val({p, ".almostFull"}, 64'(af[i]), 64'(n >= cap[i] - 2));
      check_val({p, ".almostEmpty"}, 64'(ae[i]), 64'(n <= 2));
      check_val({p, ".overflow"}, 64'(ov[i]), 64'(ovf_m[i]));
      check_val({p, ".underflow"}, 64'(un[i]), 64'(unf_m[i]));
      if (fwft[i] != 0) begin
        if (n > 0) check_val({p, ".front"}, 64'(fr[i]), 64'(q[i][0]));
      end else begin
        check_val({p, ".front"}, 64'(fr[i]), 64'(fr_m[i]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    txn++;
    $display("txn %0d rst_n=%b flush=%b enq=%b deq=%b clr=%b data=%h cnt_a=%0d cnt_b=%0d",
             txn, rst_n, flush, enqueue, dequeue, clear_errors, back_data, count_a, count_b);
    check_all();
  endtask

  task automatic drive(input logic f, input logic e, input logic d, input logic [31:0] data,
                       input logic c);
    flush = f; enqueue = e; dequeue = d; back_data = data; clear_errors = c;
    tick();
  endtask

  initial begin
    // Reset state, and requests during reset are ignored.
    enqueue = 1'b1; back_data = 32'hdead_beef;
    #2;
    check_all();
    check_val("a.empty_reset", 64'(empty_a), 64'd1);
    tick();
    #3 rst_n = 1'b1;
    enqueue = 1'b0;

    // Fill SIZE=5 instance, overflow it, drain in order.
    for (int k = 1; k <= 5; k++) drive(0, 1, 0, 32'(k), 0);
    check_val("a.count_full", 64'(count_a), 64'd5);
    check_val("a.full_set", 64'(full_a), 64'd1);
    drive(0, 1, 0, 32'd6, 0);
    check_val("a.overflow_6th", 64'(ovf_a), 64'd1);
    check_val("a.count_hold", 64'(count_a), 64'd5);
    for (int k = 1; k <= 5; k++) begin
      check_val("a.front_order", 64'(front_a), 64'(k));
      drive(0, 0, 1, 0, 0);
    end
    check_val("a.empty_drained", 64'(empty_a), 64'd1);
    drive(1, 0, 0, 0, 1);

    // Steady occupancy 2 with pointer wrap.
    drive(0, 1, 0, 32'd100, 0);
    drive(0, 1, 0, 32'd101, 0);
    for (int k = 0; k < 12; k++) drive(0, 1, 1, 32'(200 + k), 0);
    check_val("a.count_steady", 64'(count_a), 64'd2);
    check_val("a.front_wrap", 64'(front_a), 64'd210);

    // Simultaneous enqueue+dequeue on full and on empty.
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 32'(300 + k), 0);
    drive(0, 1, 1, 32'd399, 0);
    check_val("a.count_full_rw", 64'(count_a), 64'd5);
    check_val("a.no_overflow_rw", 64'(ovf_a), 64'd0);
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 1, 32'h55, 0);
    check_val("a.count_empty_rw", 64'(count_a), 64'd1);
    check_val("a.underflow_rw", 64'(unf_a), 64'd1);
    check_val("a.front_new", 64'(front_a), 64'h55);

    // SIZE=16 thresholds and flush with enqueue.
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < 13; k++) drive(0, 1, 0, 32'(400 + k), 0);
    check_val("b.almostFull_13", 64'(afull_b), 64'd0);
    drive(0, 1, 0, 32'd413, 0);
    check_val("b.almostFull_14", 64'(afull_b), 64'd1);
    for (int k = 0; k < 11; k++) drive(0, 0, 1, 0, 0);
    check_val("b.almostEmpty_3", 64'(aempty_b), 64'd0);
    drive(0, 0, 1, 0, 0);
    check_val("b.almostEmpty_2", 64'(aempty_b), 64'd1);
    for (int k = 0; k < 7; k++) drive(0, 1, 0, 32'(500 + k), 0);
    check_val("b.count_9", 64'(count_b), 64'd9);
    drive(1, 1, 0, 32'd999, 0);
    check_val("b.count_flushed", 64'(count_b), 64'd0);
    check_val("b.overflow_flush", 64'(ovf_b), 64'd0);

    // Registered read path.
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 32'hA, 0);
    drive(0, 1, 0, 32'hB, 0);
    drive(0, 0, 1, 0, 0);
    check_val("b.front_A", 64'(front_b), 64'hA);
    drive(0, 0, 0, 0, 0);
    check_val("b.front_A_hold", 64'(front_b), 64'hA);
    drive(0, 0, 1, 0, 0);
    check_val("b.front_B", 64'(front_b), 64'hB);

    // Asynchronous reset mid-burst at count 7 with overflow set.
    drive(1, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) drive(0, 1, 0, 32'(600 + k), 0);
    for (int k = 0; k < 9; k++) drive(0, 0, 1, 0, 0);
    check_val("b.count_7", 64'(count_b), 64'd7);
    check_val("b.overflow_pre", 64'(ovf_b), 64'd1);
    enqueue = 1'b1; dequeue = 1'b0; back_data = 32'h77;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("b.count_async", 64'(count_b), 64'd0);
    check_val("b.overflow_async", 64'(ovf_b), 64'd0);
    check_val("b.empty_async", 64'(empty_b), 64'd1);
    check_all();
    #2 rst_n = 1'b1;

    // Randomized traffic with occupancy-biasing phases.
    begin
      int p_enq = 50;
      for (int c = 0; c < 1500; c++) begin
        if (c % 100 == 0) p_enq = (c / 100) % 3 == 0 ? 80 : ((c / 100) % 3 == 1 ? 20 : 50);
        drive(($urandom % 100) < 1, ($urandom % 100) < 32'(p_enq),
              ($urandom % 100) < 32'(100 - p_enq), $urandom, ($urandom % 100) < 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
